// File: rtl/ao_eval_arbiter.sv
// Round-robin arbiter sharing one combinational AND-OR unit among NUM_REQ requesters.
// Optional AO_EVAL_CHECK_EN builds a reference model that flags unit output mismatches on err.
//
//   state  | meaning
//   IDLE   | scanning req_valid, accepting at most one request per cycle
//   SETTLE | unit inputs held; counter runs down to the capture edge
module ao_eval_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_a,
    input  logic [NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0] req_c,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic               rsp_out,
    output logic               unit_a,
    output logic               unit_b,
    output logic               unit_c,
    input  logic               unit_out,
    output logic               busy,
    output logic               err
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t             state, state_nxt;
    logic [GW-1:0]      last_grant, cur_grant, grant_idx, scan_idx;
    logic               grant_found;
    logic [CNT_W-1:0]   cnt;
    logic               accept, capture;
    int                 idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Priority starts just above the last winner and wraps, so a served
    // requester that keeps asserting req_valid falls to the back of the line.
    always_comb begin
        state_nxt   = state;
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        idx         = 0;
        req_ready   = '0;
        accept      = 1'b0;
        capture     = 1'b0;
        busy        = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx      = (int'(last_grant) + k) % NUM_REQ;
            scan_idx = GW'(idx);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready = NUM_REQ'(1) << grant_idx;
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_a     <= 1'b0;
            unit_b     <= 1'b0;
            unit_c     <= 1'b0;
            rsp_valid  <= '0;
            rsp_out    <= 1'b0;
            cnt        <= '0;
            cur_grant  <= '0;
            last_grant <= GW'(NUM_REQ - 1);
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                unit_a     <= req_a[grant_idx];
                unit_b     <= req_b[grant_idx];
                unit_c     <= req_c[grant_idx];
                cur_grant  <= grant_idx;
                last_grant <= grant_idx;
                cnt        <= CNT_W'(SETTLE_CYCLES - 1);
            end else if (capture) begin
                rsp_out   <= unit_out;
                rsp_valid <= NUM_REQ'(1) << cur_grant;
            end else if (state == SETTLE) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef AO_EVAL_CHECK_EN
    logic       err_q;
    logic [7:0] mismatch_cnt;
    logic       model_out;

    assign model_out = (unit_a & unit_b) | unit_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q        <= 1'b0;
            mismatch_cnt <= '0;
        end else if (capture && (model_out != unit_out)) begin
            err_q <= 1'b1;
            if (mismatch_cnt != 8'hff) mismatch_cnt <= mismatch_cnt + 8'd1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/ao_eval_arbiter.md
Name: ao_eval_arbiter

Overview:
- Shares one combinational AND-OR evaluation unit (out = (a & b) | c, worst-case propagation 9 ns) among NUM_REQ requesters.
- Round-robin arbitration over a valid/ready request handshake.
- Latches the winner's operands and drives them to the unit, then waits a programmable settle window.
- Samples the unit output and returns a one-cycle response pulse to the winning requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SETTLE_CYCLES, 2, clock cycles unit inputs are held before output is sampled (>=1; 0 illegal)
CNT_W, 4, settle counter width; must satisfy 2**CNT_W > SETTLE_CYCLES

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  per-requester request
req_a  input  NUM_REQ  operand a, bit i belongs to requester i
req_b  input  NUM_REQ  operand b, per requester
req_c  input  NUM_REQ  operand c, per requester
req_ready  output  NUM_REQ  one-hot accept, combinational
rsp_valid  output  NUM_REQ  one-hot, one-cycle result pulse
rsp_out  output  1  sampled unit result, valid with rsp_valid
unit_a  output  1  drives unit input a
unit_b  output  1  drives unit input b
unit_c  output  1  drives unit input c
unit_out  input  1  unit output
busy  output  1  high while in SETTLE
err  output  1  sticky mismatch flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=IDLE; unit_a/b/c=0; rsp_valid=0; rsp_out=0; busy=0; err=0; counter=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, SETTLE.
- IDLE:
  - req_ready is the one-hot grant g. g is the first set req_valid bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - req_ready is all-zero when req_valid=0.
  - Handshake occurs in cycle T when req_valid[g] & req_ready[g].
  - At edge T: latch req_a[g], req_b[g], req_c[g] into unit_a/b/c; store g; last_grant<=g; counter<=SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - req_ready=0 and busy=1.
  - Counter decrements each cycle.
  - At the edge where counter==0: rsp_out<=unit_out, rsp_valid[g]<=1, go to IDLE.
- Latency: accept at cycle T; unit inputs change after edge T; rsp_valid is high in cycle T+SETTLE_CYCLES+1.
- rsp_valid is high for exactly one cycle, with no backpressure. That cycle is IDLE, and a new accept may occur in it (back-to-back throughput: one result per SETTLE_CYCLES+1 cycles).
- unit_a/b/c hold their last operands until the next accept. They are never cleared except by reset.
- rsp_out holds until the next capture.
- Requester dropping req_valid during SETTLE has no effect; its accepted operation completes.
- Requester holding req_valid after being served: it is treated as a new request. Fairness guarantees every other pending requester is served first.
- Single requester: it is served every SETTLE_CYCLES+1 cycles.
- Reset mid-SETTLE: operation aborted, no rsp_valid, all outputs to reset values.

Optional Feature:
- Macro: AO_EVAL_CHECK_EN.
- Defined:
  - An internal reference model computes (unit_a & unit_b) | unit_c.
  - At each capture edge it is compared with unit_out.
  - On mismatch, err<=1 (sticky until rst) and an 8-bit saturating internal mismatch counter increments.
- Undefined: no model or counter is built; err is tied to 0. The port list is identical in both builds.

Test Plan (NUM_REQ=4, SETTLE_CYCLES=2, clk period 20 ns, unit = real AND-OR with gate delays):
- Reset: assert rst mid-cycle with no clock edge -> all outputs 0 immediately. Release rst, then req_valid=4'b0001 with a=b=1, c=0 -> req_ready=0001 in that cycle; unit_a/b/c=1/1/0 next cycle; rsp_valid=0001, rsp_out=1 three cycles after accept.
- Round-robin: req_valid=4'b1111 held continuously -> grants in order 0,1,2,3,0, one every 3 cycles; each rsp_valid matches the granted index; operands (a,b,c) = (0,0,0),(1,0,0),(0,0,1),(1,1,1) -> rsp_out 0,0,1,1.
- Wrap priority: last_grant=2, req_valid=4'b0101 -> requester 0 granted (scan order 3,0,1,2); next grant is requester 2.
- Reset mid-operation: accept requester 1, assert rst during SETTLE -> no rsp_valid pulse, unit inputs 0, busy 0. After release, requester 0 is served first.
- Back-to-back: rsp_valid cycle coincides with req_valid=4'b0010 -> accept in the same cycle as rsp_valid; no idle gap.
- With AO_EVAL_CHECK_EN: force unit_out to 0 while a=b=1 -> err=1 after the capture edge, stays 1 through later correct results until rst. Without the macro: same stimulus -> err=0.
